// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with a one-entry skid buffer, flush and a saturating stall counter.
// Define MEM_WB_FWD_EN to add the fwd_valid/fwd_reg/fwd_data forwarding outputs.
module mem_wb_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic [REG_ADDR_W-1:0] write_reg_out,
    output logic [DATA_W-1:0]     alu_res_out,
    output logic [DATA_W-1:0]     read_data_out,
    output logic [DATA_W-1:0]     wb_data,
`ifdef MEM_WB_FWD_EN
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     read_data;
    } beat_t;

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    beat_t            out_beat_q, out_beat_d;
    beat_t            skid_beat_q, skid_beat_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    beat_t in_beat;
    logic  accept;

    assign in_beat = '{reg_write:  reg_write,
                       mem_to_reg: mem_to_reg,
                       write_reg:  write_reg,
                       alu_result: alu_result,
                       read_data:  read_data};

    // in_ready is purely registered state, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // Skid full implies in_ready = 0, so no beat can arrive this cycle.
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_beat_d  = in_beat;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_beat_q   <= '0;
            skid_beat_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_beat_q   <= out_beat_d;
            skid_beat_q  <= skid_beat_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign reg_write_out  = out_beat_q.reg_write;
    assign mem_to_reg_out = out_beat_q.mem_to_reg;
    assign write_reg_out  = out_beat_q.write_reg;
    assign alu_res_out    = out_beat_q.alu_result;
    assign read_data_out  = out_beat_q.read_data;
    assign wb_data        = out_beat_q.mem_to_reg ? out_beat_q.read_data : out_beat_q.alu_result;
    assign stall_cnt      = stall_cnt_q;

`ifdef MEM_WB_FWD_EN
    assign fwd_valid = out_valid_q && out_beat_q.reg_write;
    assign fwd_reg   = out_beat_q.write_reg;
    assign fwd_data  = wb_data;
`endif

endmodule
